// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation, single-outstanding imem requests,
// 2-entry prefetch buffer feeding the IF/ID registers, redirect flush.
module fetch_stage #(
    parameter logic [15:0] PC_RESET  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_req,
    output logic [15:0] o_imem_addr,
    input  logic        i_imem_rvalid,
    input  logic [15:0] i_imem_rdata,
    input  logic        i_id_stall,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    output logic        o_if_id_write_n,
    output logic [15:0] o_if_id_instr,
    output logic [15:0] o_if_id_pc,
    output logic        o_if_id_valid
);

    typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_DROP} state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_req_pc;
    logic [15:0] r_buf_instr [2];
    logic [15:0] r_buf_pc    [2];
    logic        r_head;
    logic [1:0]  r_count;

    logic        w_push;
    logic        w_pop;
    logic        w_issue;
    logic        w_tail;
    logic [1:0]  w_count_after;

    assign w_push        = (r_state == ST_WAIT) && i_imem_rvalid && !i_redirect && !i_reset;
    assign w_pop         = (r_count != 2'd0) && !i_id_stall && !i_redirect && !i_reset;
    assign w_count_after = r_count + {1'b0, w_push} - {1'b0, w_pop};
    // The buffer never holds more than two entries, so count[0] gives the tail offset.
    assign w_tail        = r_head ^ r_count[0];

    // A new request is only launched if a buffer slot is guaranteed for its response.
    always_comb begin
        w_issue = 1'b0;
        if (!i_reset && !i_redirect) begin
            if (r_state == ST_ISSUE) begin
                w_issue = (r_count < 2'd2);
            end else if (r_state == ST_WAIT) begin
                w_issue = i_imem_rvalid && (w_count_after < 2'd2);
            end
        end
    end

    always_comb begin
        o_imem_req      = w_issue;
        o_imem_addr     = r_pc;
        o_if_id_write_n = 1'b1;
        o_if_id_valid   = 1'b0;
        o_if_id_instr   = NOP_INSTR;
        o_if_id_pc      = 16'h0000;
        if (i_reset) begin
            o_if_id_write_n = 1'b1;
        end else if (i_redirect) begin
            o_if_id_write_n = 1'b0;
            o_if_id_pc      = i_redirect_pc;
        end else if (r_count != 2'd0) begin
            o_if_id_instr   = r_buf_instr[r_head];
            o_if_id_pc      = r_buf_pc[r_head];
            o_if_id_write_n = i_id_stall;
            o_if_id_valid   = !i_id_stall;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_ISSUE;
            r_pc           <= PC_RESET;
            r_req_pc       <= 16'h0000;
            r_head         <= 1'b0;
            r_count        <= 2'd0;
            r_buf_instr[0] <= NOP_INSTR;
            r_buf_instr[1] <= NOP_INSTR;
            r_buf_pc[0]    <= 16'h0000;
            r_buf_pc[1]    <= 16'h0000;
        end else if (i_redirect) begin
            r_pc    <= i_redirect_pc;
            r_count <= 2'd0;
            r_head  <= 1'b0;
            // A response still in flight must be swallowed before refetching.
            if ((r_state != ST_ISSUE) && !i_imem_rvalid) begin
                r_state <= ST_DROP;
            end else begin
                r_state <= ST_ISSUE;
            end
        end else begin
            if (w_push) begin
                r_buf_instr[w_tail] <= i_imem_rdata;
                r_buf_pc[w_tail]    <= r_req_pc;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= w_count_after;
            if (w_issue) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + 16'd1;
                r_state  <= ST_WAIT;
            end else if ((r_state != ST_ISSUE) && i_imem_rvalid) begin
                r_state <= ST_ISSUE;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a latency-programmable memory model feeds
// the DUT, and a reference model predicts every IF/ID write.
module tb_fetch_stage;

    localparam logic [15:0] BASE = 16'h0100;
    localparam logic [15:0] NOP  = 16'hE000;

    typedef struct {
        int          due;
        logic [15:0] addr;
    } mreq_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } sb_t;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        o_imem_req;
    logic [15:0] o_imem_addr;
    logic        i_imem_rvalid;
    logic [15:0] i_imem_rdata;
    logic        i_id_stall;
    logic        i_redirect;
    logic [15:0] i_redirect_pc;
    logic        o_if_id_write_n;
    logic [15:0] o_if_id_instr;
    logic [15:0] o_if_id_pc;
    logic        o_if_id_valid;

    logic        wr_imem_req;
    logic [15:0] wr_imem_addr;
    logic        wr_rvalid;
    logic [15:0] wr_rdata;
    logic        wr_if_id_write_n;
    logic [15:0] wr_if_id_instr;
    logic [15:0] wr_if_id_pc;
    logic        wr_if_id_valid;

    always #5 clk = ~clk;

    fetch_stage #(.PC_RESET(BASE), .NOP_INSTR(NOP)) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .o_imem_req      (o_imem_req),
        .o_imem_addr     (o_imem_addr),
        .i_imem_rvalid   (i_imem_rvalid),
        .i_imem_rdata    (i_imem_rdata),
        .i_id_stall      (i_id_stall),
        .i_redirect      (i_redirect),
        .i_redirect_pc   (i_redirect_pc),
        .o_if_id_write_n (o_if_id_write_n),
        .o_if_id_instr   (o_if_id_instr),
        .o_if_id_pc      (o_if_id_pc),
        .o_if_id_valid   (o_if_id_valid)
    );

    fetch_stage #(.PC_RESET(16'hFFFF), .NOP_INSTR(NOP)) dut_wrap (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .o_imem_req      (wr_imem_req),
        .o_imem_addr     (wr_imem_addr),
        .i_imem_rvalid   (wr_rvalid),
        .i_imem_rdata    (wr_rdata),
        .i_id_stall      (1'b0),
        .i_redirect      (1'b0),
        .i_redirect_pc   (16'h0000),
        .o_if_id_write_n (wr_if_id_write_n),
        .o_if_id_instr   (wr_if_id_instr),
        .o_if_id_pc      (wr_if_id_pc),
        .o_if_id_valid   (wr_if_id_valid)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          n_req;
    int          n_wr;
    int          k;
    mreq_t       mem_q[$];
    sb_t         sb_q[$];
    logic [15:0] wrap_addrs[$];
    logic [15:0] wrap_pcs[$];
    logic [15:0] wrap_instrs[$];
    logic        outstanding = 1'b0;
    logic        dropping    = 1'b0;
    logic [15:0] exp_pc      = BASE;
    logic        resp_v;
    logic [15:0] resp_addr;
    logic        w_pend      = 1'b0;
    logic [15:0] w_pend_addr = 16'h0000;
    logic        s_req, s_wn, s_valid;
    logic [15:0] s_addr, s_instr, s_pc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a + 16'h9F01;
    endfunction

    // One clock cycle: drive memory responses, sample at negedge, run the model.
    task automatic tick();
        sb_t e;
        resp_v        = 1'b0;
        resp_addr     = 16'h0000;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 16'h0000;
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            resp_v        = 1'b1;
            resp_addr     = mem_q[0].addr;
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_word(resp_addr);
            void'(mem_q.pop_front());
        end
        wr_rvalid = w_pend;
        wr_rdata  = w_pend_addr ^ 16'h5A5A;

        @(negedge clk);
        s_req   = o_imem_req;
        s_addr  = o_imem_addr;
        s_wn    = o_if_id_write_n;
        s_valid = o_if_id_valid;
        s_instr = o_if_id_instr;
        s_pc    = o_if_id_pc;
        if (s_req) n_req++;
        if (!s_wn && s_valid) n_wr++;

        if (i_reset) begin
            wrap_addrs.delete();
            wrap_pcs.delete();
            wrap_instrs.delete();
        end else begin
            if (wr_imem_req) wrap_addrs.push_back(wr_imem_addr);
            if (!wr_if_id_write_n) begin
                check_eq("wrap_valid", wr_if_id_valid, 1);
                wrap_pcs.push_back(wr_if_id_pc);
                wrap_instrs.push_back(wr_if_id_instr);
            end
        end
        w_pend      = wr_imem_req && !i_reset;
        w_pend_addr = wr_imem_addr;

        if (i_reset) begin
            check_eq("rst_req", s_req, 0);
            check_eq("rst_write_n", s_wn, 1);
            check_eq("rst_valid", s_valid, 0);
            check_eq("rst_instr", s_instr, NOP);
            check_eq("rst_pc", s_pc, 0);
            sb_q.delete();
            exp_pc      = BASE;
            outstanding = 1'b0;
            dropping    = 1'b0;
        end else begin
            if (i_redirect) begin
                check_eq("bubble_write_n", s_wn, 0);
                check_eq("bubble_valid", s_valid, 0);
                check_eq("bubble_instr", s_instr, NOP);
                check_eq("bubble_pc", s_pc, i_redirect_pc);
                check_eq("bubble_no_req", s_req, 0);
            end else if (i_id_stall) begin
                check_eq("stall_hold", s_wn, 1);
                if (sb_q.size() != 0) check_eq("stall_head_pc", s_pc, sb_q[0].pc);
            end else if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("out_write_n", s_wn, 0);
                check_eq("out_valid", s_valid, 1);
                check_eq("out_instr", s_instr, e.instr);
                check_eq("out_pc", s_pc, e.pc);
            end else begin
                check_eq("idle_write_n", s_wn, 1);
                check_eq("idle_instr", s_instr, NOP);
                check_eq("idle_pc", s_pc, 0);
            end

            if (resp_v && outstanding) begin
                if (!dropping && !i_redirect) sb_q.push_back('{mem_word(resp_addr), resp_addr});
                outstanding = 1'b0;
                dropping    = 1'b0;
            end
            if (i_redirect) begin
                sb_q.delete();
                exp_pc = i_redirect_pc;
                if (outstanding) dropping = 1'b1;
            end
            if (s_req) begin
                check_eq("req_addr", s_addr, exp_pc);
                check_eq("req_single_outstanding", outstanding, 0);
                mem_q.push_back('{cyc + lat, exp_pc});
                outstanding = 1'b1;
                exp_pc      = exp_pc + 16'd1;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        i_reset       = 1'b1;
        i_id_stall    = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 16'h0000;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 16'h0000;
        wr_rvalid     = 1'b0;
        wr_rdata      = 16'h0000;
        n_req         = 0;
        n_wr          = 0;

        // Reset, first fetches and L=1 streaming
        repeat (3) tick();
        i_reset = 1'b0;
        tick();
        check_eq("t1_first_req", s_req, 1);
        check_eq("t1_first_addr", s_addr, 16'h0100);
        tick();
        check_eq("t1_second_addr", s_addr, 16'h0101);
        check_eq("t1_no_write_yet", s_wn, 1);
        tick();
        check_eq("t1_w0_write_n", s_wn, 0);
        check_eq("t1_w0_instr", s_instr, 16'hA001);
        check_eq("t1_w0_pc", s_pc, 16'h0100);
        tick();
        check_eq("t1_w1_write_n", s_wn, 0);
        check_eq("t1_w1_instr", s_instr, 16'hA002);
        check_eq("t1_w1_pc", s_pc, 16'h0101);
        n_wr = 0;
        repeat (8) tick();
        check_eq("t1_throughput", n_wr, 8);

        // Stall fills the buffer, then drains in order
        i_redirect    = 1'b1;
        i_redirect_pc = 16'h0200;
        tick();
        check_eq("t2_bubble_pc", s_pc, 16'h0200);
        i_redirect = 1'b0;
        i_id_stall = 1'b1;
        n_req      = 0;
        repeat (6) tick();
        check_eq("t2_req_count", n_req, 2);
        check_eq("t2_req_idle", s_req, 0);
        i_id_stall = 1'b0;
        tick();
        check_eq("t2_drain0_write_n", s_wn, 0);
        check_eq("t2_drain0_pc", s_pc, 16'h0200);
        check_eq("t2_drain0_instr", s_instr, mem_word(16'h0200));
        tick();
        check_eq("t2_drain1_write_n", s_wn, 0);
        check_eq("t2_drain1_pc", s_pc, 16'h0201);
        check_eq("t2_resume_req", s_req, 1);
        check_eq("t2_resume_addr", s_addr, 16'h0202);

        // Redirect while an L=3 request is outstanding
        lat = 3;
        k   = 0;
        do begin tick(); k++; end while (!s_req && k < 10);
        check_eq("t3_req_seen", s_req, 1);
        i_redirect    = 1'b1;
        i_redirect_pc = 16'h0040;
        tick();
        i_redirect = 1'b0;
        k = 0;
        do begin tick(); k++; end while (!s_req && k < 10);
        check_eq("t3_drop_wait", k, 3);
        check_eq("t3_new_addr", s_addr, 16'h0040);
        k = 0;
        do begin tick(); k++; end while (s_wn && k < 20);
        check_eq("t3_latency", k, 4);
        check_eq("t3_first_pc", s_pc, 16'h0040);
        check_eq("t3_first_instr", s_instr, mem_word(16'h0040));

        // Redirect with stall high and a full buffer
        lat        = 1;
        i_id_stall = 1'b1;
        repeat (10) tick();
        check_eq("t4_full_idle", s_req, 0);
        i_redirect    = 1'b1;
        i_redirect_pc = 16'h0300;
        tick();
        check_eq("t4_bubble_write_n", s_wn, 0);
        check_eq("t4_bubble_pc", s_pc, 16'h0300);
        i_redirect = 1'b0;
        tick();
        check_eq("t4_flushed_write_n", s_wn, 1);
        check_eq("t4_flushed_instr", s_instr, NOP);
        check_eq("t4_refetch_addr", s_addr, 16'h0300);
        i_id_stall = 1'b0;
        k = 0;
        do begin tick(); k++; end while (s_wn && k < 10);
        check_eq("t4_first_pc", s_pc, 16'h0300);

        // Reset in the middle of an L=4 request
        lat = 4;
        k   = 0;
        do begin tick(); k++; end while (!s_req && k < 10);
        check_eq("t5_req_seen", s_req, 1);
        i_reset = 1'b1;
        repeat (6) tick();
        i_reset = 1'b0;
        tick();
        check_eq("t5_req", s_req, 1);
        check_eq("t5_addr", s_addr, 16'h0100);
        check_eq("t5_write_n", s_wn, 1);
        k = 0;
        do begin tick(); k++; end while (s_wn && k < 10);
        check_eq("t5_first_pc", s_pc, 16'h0100);
        check_eq("t5_first_instr", s_instr, 16'hA001);
        repeat (4) tick();

        // PC wrap on the second instance
        check_eq("wrap_req_count", wrap_addrs.size() >= 3, 1);
        if (wrap_addrs.size() >= 3) begin
            check_eq("wrap_addr0", wrap_addrs[0], 16'hFFFF);
            check_eq("wrap_addr1", wrap_addrs[1], 16'h0000);
            check_eq("wrap_addr2", wrap_addrs[2], 16'h0001);
        end
        check_eq("wrap_write_count", wrap_pcs.size() >= 2, 1);
        if (wrap_pcs.size() >= 2) begin
            check_eq("wrap_pc0", wrap_pcs[0], 16'hFFFF);
            check_eq("wrap_pc1", wrap_pcs[1], 16'h0000);
            check_eq("wrap_instr0", wrap_instrs[0], 16'hA5A5);
            check_eq("wrap_instr1", wrap_instrs[1], 16'h5A5A);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit pipeline. It generates the PC and issues single-outstanding requests to instruction memory. Returned words are held in a 2-entry prefetch buffer, and one (instruction, PC) pair per cycle is presented to the IF/ID pipeline registers. It drives the IF/ID active-low write strobe, honours decode stalls, and flushes on branch redirects from later stages.

## Interface
Parameters:
- PC_RESET, 16'h0000, PC loaded by reset.
- NOP_INSTR, 16'h0000, instruction word used for flush bubbles and idle output.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  request strobe, one cycle per request (combinational).
- imem_addr  out  16  word address of the request; equals pc register.
- imem_rvalid  in  1  response valid, ≥1 cycle after the request.
- imem_rdata  in  16  instruction word, valid with imem_rvalid.
- id_stall  in  1  high = IF/ID must hold its contents.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  16  new fetch address, valid with redirect.
- if_id_write_n  out  1  active-low write enable to IF/ID registers.
- if_id_instr  out  16  instruction to IF/ID.
- if_id_pc  out  16  PC of if_id_instr.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.

## Operation
- State: pc (next fetch address), req_pc (address of the outstanding request), 2-entry FIFO of {instr, pc}, count 0..2, FSM {ISSUE, WAIT, DROP}.
- PC addressing is by word. pc increments by 1 per issued request and wraps from 16'hFFFF to 16'h0000.
- Issue: imem_req=1 when no redirect and either of these holds:
  - state=ISSUE and count<2.
  - state=WAIT, imem_rvalid=1, and count after this cycle's push/pop is <2 (back-to-back issue).
- On issue: req_pc<=pc, pc<=pc+1, state<=WAIT.
- WAIT with imem_rvalid: push {imem_rdata, req_pc}. If no re-issue, state<=ISSUE. Overflow cannot occur because the issue rule reserves a slot.
- Output: when count>0 and id_stall=0:
  - if_id_write_n=0, head entry on if_id_instr/if_id_pc, if_id_valid=1.
  - The head pops on the same posedge.
  - With id_stall=1 or count=0: if_id_write_n=1. Data outputs show the head, or NOP_INSTR/0 when empty.
- Simultaneous push and pop: count unchanged; ordering is preserved.
- Redirect has highest priority and overrides id_stall:
  - That cycle: if_id_write_n=0, if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc=redirect_pc.
  - FIFO cleared and pc<=redirect_pc.
  - If a request is outstanding and imem_rvalid is not asserted this cycle: state<=DROP. Otherwise state<=ISSUE, and any same-cycle rvalid is discarded.
- DROP: no issue. The next imem_rvalid is discarded, then state<=ISSUE. A further redirect in DROP reloads pc and stays in DROP.

## Timing
- Reset values (registered on the first posedge with reset=1):
  - pc=PC_RESET, req_pc=0, count=0, state=ISSUE.
  - Outputs: imem_req=0, if_id_write_n=1, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0.
- imem_req is forced 0 while reset=1. Reset mid-request abandons the transaction, and the in-flight response is ignored (state=ISSUE, no outstanding request).
- Memory latency L≥1: a request at cycle t with rvalid at t+L has its word present at IF/ID in cycle t+L+1 if not stalled. The IF/ID registers capture it at the end of that cycle.
- Sustained throughput with L=1 and no stalls: 1 instruction/cycle after a 2-cycle startup.
- Redirect to first new instruction on IF/ID write: L+2 cycles, plus the remaining latency of any dropped response.

## Test plan
- Reset with PC_RESET=16'h0100: first imem_req in the cycle after reset deasserts, imem_addr=0x0100. Words 0xA001, 0xA002 (L=1) appear with if_id_pc 0x0100, 0x0101 on consecutive if_id_write_n=0 cycles.
- Hold id_stall=1 for 6 cycles with L=1: exactly 2 requests are issued and then imem_req stays 0. On release, the two buffered words drain in order on back-to-back cycles, and fetching resumes at pc=base+2.
- Redirect to 0x0040 while a request with L=3 is outstanding: the bubble cycle shows if_id_write_n=0 and if_id_valid=0. The late response is discarded. The next request has imem_addr=0x0040.
- Redirect concurrent with id_stall=1 and count=2: the bubble is written anyway, count goes to 0, and no stale instruction ever reaches IF/ID.
- PC wrap: with PC_RESET=16'hFFFF, the sequence of fetch addresses is 0xFFFF, then 0x0000.
- Assert reset mid-WAIT with a pending response: all outputs return to their reset values, and the later rvalid does not push.
